// File: rtl/phase_readout.sv
// Phase readout: synchronizes the oscillator outputs, counts mismatches against oscillator 0
// over a fixed window and resolves one spin bit per oscillator. Optional feature macro: PHASE_COUNTS_EN.
`ifndef PHASE_ADDR_MASK
`define PHASE_ADDR_MASK 32'hFFFF_F000
`endif
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h4000_0000
`endif

module phase_readout #(
    parameter int N           = 8,
    parameter int WINDOW      = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          axi_rstn,
    input  logic [N-1:0]  osc_in,
    input  logic          wready,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wdata,
    input  logic          rd_req,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rdata,
    output logic          rvalid,
    output logic          busy,
    output logic          done
);

    localparam int CW  = $clog2(WINDOW + 1);
    localparam int CYW = $clog2(WINDOW);
    localparam int NW  = (N + 31) / 32;

    typedef enum logic [1:0] {IDLE, SAMPLE, RESOLVE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_sync [SYNC_STAGES];
    logic [N-1:0]    w_s;
    logic [CYW-1:0]  r_cyc;
    logic [CW-1:0]   r_cnt [N];
    logic [N-1:0]    r_spin;
    logic            r_done;
    logic            w_start;
    logic            w_clr;
    logic            w_count;
    logic            w_resolve;
    logic            w_rd_hit;
    logic [11:0]     w_off;
    logic [31:0]     w_rd_data;
    logic [NW*32-1:0] w_spin_pad;
    logic            w_unused_wdata;
`ifdef PHASE_COUNTS_EN
    logic [CW-1:0]   r_cres [N];
`endif

    assign w_unused_wdata = &{1'b0, wdata[31:1]};

    assign w_start = wready && ((wr_addr & `PHASE_ADDR_MASK) == `PHASE_ADDR_BASE)
                     && (wr_addr[11:0] == 12'h000) && wdata[0];

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign w_s  = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= osc_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_count     = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = SAMPLE;
                    w_clr       = 1'b1;
                end
            end
            SAMPLE: begin
                w_count = 1'b1;
                if (r_cyc == CYW'(WINDOW - 1)) w_state_nxt = RESOLVE;
            end
            RESOLVE: begin
                w_resolve   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Oscillator 0 is the reference, so its own mismatch term is always zero.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_cyc <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else if (w_clr) begin
            r_cyc <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else if (w_count) begin
            r_cyc <= r_cyc + 1'b1;
            for (int i = 0; i < N; i++) r_cnt[i] <= r_cnt[i] + CW'(w_s[i] ^ w_s[0]);
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_spin <= '0;
`ifdef PHASE_COUNTS_EN
            for (int i = 0; i < N; i++) r_cres[i] <= '0;
`endif
        end else if (w_resolve) begin
            for (int i = 0; i < N; i++) r_spin[i] <= (r_cnt[i] > CW'(WINDOW / 2));
`ifdef PHASE_COUNTS_EN
            for (int i = 0; i < N; i++) r_cres[i] <= r_cnt[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn)      r_done <= 1'b0;
        else if (w_clr)     r_done <= 1'b0;
        else if (w_resolve) r_done <= 1'b1;
    end

    always_comb begin
        w_spin_pad          = '0;
        w_spin_pad[N-1:0]   = r_spin;
    end

    // Read mux sees the result registers before any same-cycle RESOLVE update.
    always_comb begin
        w_rd_hit  = rd_req && ((rd_addr & `PHASE_ADDR_MASK) == `PHASE_ADDR_BASE);
        w_off     = rd_addr[11:0];
        w_rd_data = '0;
        if (w_off == 12'h000) w_rd_data = {30'b0, busy, done};
        for (int w = 0; w < NW; w++) begin
            if (w_off == 12'(4 + 4 * w)) w_rd_data = w_spin_pad[w*32 +: 32];
        end
`ifdef PHASE_COUNTS_EN
        for (int i = 0; i < N; i++) begin
            if (w_off == 12'(256 + 4 * i)) w_rd_data = 32'(r_cres[i]);
        end
`endif
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= w_rd_hit;
            if (w_rd_hit) rdata <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_phase_readout.sv
// Scoreboard bench for phase_readout (N=8, WINDOW=16): directed oscillator patterns,
// expected read data queued at issue time and checked by an independent monitor.
`ifndef PHASE_ADDR_MASK
`define PHASE_ADDR_MASK 32'hFFFF_F000
`endif
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE 32'h4000_0000
`endif

module tb_phase_readout;

    localparam int N      = 8;
    localparam int WINDOW = 16;
    localparam int SYNC   = 2;
    localparam logic [31:0] BASE  = `PHASE_ADDR_BASE;
    localparam logic [31:0] SPIN0 = `PHASE_ADDR_BASE + 32'h4;
`ifdef PHASE_COUNTS_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic         clk;
    logic         axi_rstn;
    logic [N-1:0] osc_in;
    logic         wready;
    logic [31:0]  wr_addr;
    logic [31:0]  wdata;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic [31:0]  rdata;
    logic         rvalid;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;
    int kmis     = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    phase_readout #(.N(N), .WINDOW(WINDOW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .axi_rstn(axi_rstn), .osc_in(osc_in),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // Mode 0: all equal and toggling. Mode 1: osc[5:1] inverse of osc[0].
    // Mode 2: osc[2] high for kmis of every 16 cycles, all others low.
    initial begin
        logic [7:0] ph;
        ph = '0;
        osc_in = '0;
        forever begin
            @(negedge clk);
            ph = ph + 8'd1;
            case (mode)
                0: osc_in = {N{ph[0]}};
                1: osc_in = {ph[0], ph[0], {5{~ph[0]}}, ph[0]};
                default: begin
                    osc_in = '0;
                    osc_in[2] = (int'(ph[3:0]) < kmis);
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=0x%08h required no response", rdata);
            end else begin
                chk(name_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        rd_req = 1'b0;
        wready = 1'b0;
    endtask

    task automatic issue_rd(input logic [31:0] a, input logic [31:0] e, input string n);
        rd_req  = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic start_wr();
        wready  = 1'b1;
        wr_addr = BASE;
        wdata   = 32'h1;
    endtask

    function automatic logic [31:0] cnt_addr(input int i);
        return BASE + 32'h100 + 32'(4 * i);
    endfunction

    task automatic set_mode(input int m, input int k);
        mode = m;
        kmis = k;
        repeat (4) step();
    endtask

    task automatic measure(input string tag, input logic [31:0] spin, input int ci, input int cexp);
        int k;
        k = 0;
        step();
        start_wr();
        step();
        k = 1;
        chk1({tag, "_busy_t1"}, busy, 1'b1);
        while (!done && k < 4 * WINDOW) begin
            step();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(WINDOW + 2));
        chk1({tag, "_busy_end"}, busy, 1'b0);
        issue_rd(SPIN0, spin, {tag, "_spin"});
        step();
        issue_rd(cnt_addr(ci), CEN ? 32'(cexp) : 32'h0, {tag, "_count"});
        step();
        step();
    endtask

    initial begin
        axi_rstn = 1'b0;
        rd_req = 1'b0; wready = 1'b0; wr_addr = '0; wdata = '0; rd_addr = '0;
        repeat (3) step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        axi_rstn = 1'b1;
        step();
        issue_rd(BASE, 32'h0, "status_after_reset");
        step();
        issue_rd(SPIN0 + 32'h4, 32'h0, "unused_spin_word");
        step();
        rd_req = 1'b1;
        rd_addr = 32'h5000_0000;
        step();
        chk1("unmatched_read_no_rvalid", rvalid, 1'b0);

        wready = 1'b1; wr_addr = BASE + 32'h4; wdata = 32'h1;
        step();
        wready = 1'b1; wr_addr = 32'h5000_0000; wdata = 32'h1;
        step();
        chk1("ignored_writes_busy", busy, 1'b0);

        set_mode(0, 0);
        measure("equal", 32'h0, 3, 0);
        set_mode(1, 0);
        measure("inverse", 32'h0000_003E, 5, 16);
        set_mode(2, 8);
        measure("half8", 32'h0, 2, 8);
        set_mode(2, 9);
        measure("half9", 32'h0000_0004, 2, 9);

        // Second start mid-measurement and reads around RESOLVE.
        set_mode(1, 0);
        step();
        start_wr();
        issue_rd(BASE, 32'h1, "status_with_start");
        for (int k = 1; k <= WINDOW + 2; k++) begin
            step();
            if (k == 1) begin
                chk1("busy_t1", busy, 1'b1);
                chk1("done_cleared_t1", done, 1'b0);
            end
            if (k == 2) issue_rd(BASE, 32'h2, "status_busy");
            if (k == 3) start_wr();
            if (k == 5) issue_rd(SPIN0, 32'h0000_0004, "spin_during_busy");
            if (k == WINDOW + 1) begin
                chk1("done_low_resolve", done, 1'b0);
                chk1("busy_high_resolve", busy, 1'b1);
                issue_rd(SPIN0, 32'h0000_0004, "spin_in_resolve");
            end
            if (k == WINDOW + 2) begin
                chk1("done_high_t_w2", done, 1'b1);
                chk1("busy_low_t_w2", busy, 1'b0);
                issue_rd(SPIN0, 32'h0000_003E, "spin_after_resolve");
            end
        end
        step();
        step();

        // Reset mid-measurement.
        step();
        start_wr();
        for (int k = 1; k <= 5; k++) step();
        axi_rstn = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        step();
        axi_rstn = 1'b1;
        step();
        issue_rd(SPIN0, 32'h0, "midrst_spin");
        step();
        issue_rd(cnt_addr(5), 32'h0, "midrst_count5");
        step();
        issue_rd(BASE, 32'h0, "midrst_status");
        repeat (WINDOW + 4) step();
        chk1("midrst_no_done", done, 1'b0);
        chk1("midrst_no_busy", busy, 1'b0);
        measure("fresh", 32'h0000_003E, 5, 16);

        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/phase_readout.md
# phase_readout

Read-side companion to the weight-programming write port of the oscillator core matrix. It samples the free-running oscillator outputs of the array against oscillator 0 over a fixed window and resolves one spin bit per oscillator. It returns spins, status and optional per-oscillator mismatch counts on a register read port that shares the clock, reset and address map with the weight writes.

## Interface
- `N`, 8: number of oscillators; legal range 2..64.
- `WINDOW`, 1024: sample cycles per measurement; must be even and ≥ 4.
- `SYNC_STAGES`, 2: synchronizer depth per oscillator bit; must be ≥ 2.
- `clk` input 1: system clock; the only clock in the block.
- `axi_rstn` input 1: asynchronous active-low reset.
- `osc_in` input N: oscillator outputs from the core matrix, asynchronous to `clk`.
- `wready` input 1: write strobe, one cycle per write.
- `wr_addr` input 32: write address.
- `wdata` input 32: write data.
- `rd_req` input 1: read strobe, one cycle per read.
- `rd_addr` input 32: read address, sampled when `rd_req`=1.
- `rdata` output 32: read data.
- `rvalid` output 1: one-cycle pulse qualifying `rdata`.
- `busy` output 1: a measurement is in progress.
- `done` output 1: results are valid; set at end of measurement, cleared by the next start.

## Operation
- Block select: `(addr & PHASE_ADDR_MASK) == PHASE_ADDR_BASE`, using the macros in `defines.vh`. The offset is `addr[11:0]`.
- Register map:
  - 0x000 CTRL/STATUS. Write: bit0=1 starts a measurement. Read: {30'b0, busy, done}.
  - 0x004+4w SPIN word w, for w = 0..ceil(N/32)-1. Bit b holds spin[32w+b]; unused bits read 0.
  - 0x100+4i COUNT i, for i < N. Holds the mismatch count of oscillator i, zero-extended. Present only with the macro in Configuration.
  - Any other matched offset reads 0. Writes to any offset other than 0x000 are ignored.
- Each `osc_in[i]` passes through a `SYNC_STAGES`-flop synchronizer, giving `s[i]`.
- FSM has three states: IDLE, SAMPLE, RESOLVE.
  - IDLE → SAMPLE on a valid start write. On this transition all counters clear and `done` clears.
  - SAMPLE lasts exactly `WINDOW` cycles. Each cycle, `cnt[i]` increments when `s[i] ^ s[0]` is 1. A cycle counter runs 0..WINDOW-1.
  - SAMPLE → RESOLVE when the cycle counter reaches WINDOW-1.
  - RESOLVE: `spin[i] = (cnt[i] > WINDOW/2)`. Spin and count result registers update together. `done` is set and the FSM returns to IDLE.
- `spin[0]` and `cnt[0]` are always 0.
- Counter width is `$clog2(WINDOW+1)`. Counters cannot saturate, since the maximum value is WINDOW.
- Result registers hold until the next RESOLVE. A read during `busy` returns the previous results, never partial counts.
- A start write while `busy`=1 is ignored.

## Timing
- Reset value of every output is 0: `rdata`, `rvalid`, `busy`, `done`. Reset also clears the FSM (to IDLE), all counters, the result registers and the synchronizers.
- Start write accepted in cycle t: `busy`=1 from t+1. The last sample is taken at t+WINDOW. RESOLVE occurs at t+WINDOW+1. From t+WINDOW+2, `busy`=0, `done`=1 and the results are readable.
- Read latency is 1 cycle. `rd_req` at cycle t gives `rvalid`=1 with `rdata` at t+1.
  - Back-to-back reads are accepted every cycle.
  - An unmatched `rd_req` produces no `rvalid`.
- A read issued in the RESOLVE cycle returns the pre-update results. A read one cycle later returns the new results.
- If a read and a start write occur in the same cycle, the read returns the pre-start status (`busy`=0).
- Reset asserted mid-measurement aborts it immediately. No `done` follows.
- Input-to-count latency is `SYNC_STAGES` cycles. Oscillator transitions within the first `SYNC_STAGES` sample cycles reflect pre-start levels; this is accepted.

## Configuration
- `PHASE_COUNTS_EN` defined: per-oscillator count registers are kept and readable at 0x100+4i.
- `PHASE_COUNTS_EN` undefined: count result registers are not built. Reads at 0x100+ return 0. Spin resolution and all timing are unchanged.

## Test plan
- Reset, then read 0x000 → `rvalid` at the next cycle with `rdata`=0. `busy`=0 and `done`=0.
- N=8, WINDOW=16, all `osc_in` tied equal and toggling. Start, wait for `done`, read 0x004 → 0x00000000, and COUNT 3 = 0.
- N=8, WINDOW=16, `osc_in[5:1]` the inverse of `osc_in[0]`. Start, then read 0x004 → 0x0000003E. COUNT 5 = 16 (macro on), or 0 (macro off).
- `osc_in[2]` mismatching exactly 8 of 16 cycles → spin[2]=0. Exactly 9 of 16 → spin[2]=1.
- A second start written at t+3 is ignored: `done` still rises at t+WINDOW+2. A read of 0x004 during `busy` returns the previous measurement's value.
- `axi_rstn` pulsed low at t+5 → `busy`=0, `done`=0, and all results read 0. A fresh start then completes normally.
